// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and memory-side handshake bundle for mem_arbiter.
//   slave  : arbiter view (takes cache requests and memory responses, drives the rest)
//   master : environment view (caches plus memory model)
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
);
  logic                  ic_req_valid;
  logic [ADDR_WIDTH-1:0] ic_req_addr;
  logic                  ic_rsp_valid;
  logic [LINE_WIDTH-1:0] ic_rsp_data;
  logic                  dc_req_valid;
  logic [ADDR_WIDTH-1:0] dc_req_addr;
  logic                  dc_req_is_store;
  logic [LINE_WIDTH-1:0] dc_req_data;
  logic                  dc_rsp_valid;
  logic [LINE_WIDTH-1:0] dc_rsp_data;
  logic                  mem_req_valid;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_is_store;
  logic [LINE_WIDTH-1:0] mem_req_data;
  logic                  mem_rsp_valid;
  logic [LINE_WIDTH-1:0] mem_rsp_data;
  modport slave (
    input  ic_req_valid, ic_req_addr, dc_req_valid, dc_req_addr, dc_req_is_store, dc_req_data,
           mem_rsp_valid, mem_rsp_data,
    output ic_rsp_valid, ic_rsp_data, dc_rsp_valid, dc_rsp_data,
           mem_req_valid, mem_req_addr, mem_req_is_store, mem_req_data
  );
  modport master (
    output ic_req_valid, ic_req_addr, dc_req_valid, dc_req_addr, dc_req_is_store, dc_req_data,
           mem_rsp_valid, mem_rsp_data,
    input  ic_rsp_valid, ic_rsp_data, dc_rsp_valid, dc_rsp_data,
           mem_req_valid, mem_req_addr, mem_req_is_store, mem_req_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port between I$ and D$ miss traffic.
//   i_clock        system clock
//   i_reset        synchronous reset, active-low
//   bus            cache request/response and memory request/response bundle (slave view)
//   o_protocol_err sticky flag: pulse into a busy slot, or memory response with nothing in flight
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
) (
  input  logic           i_clock,
  input  logic           i_reset,
  mem_arbiter_if.slave   bus,
  output logic           o_protocol_err
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t                r_state, w_next;
  logic                  r_ic_pend, r_dc_pend, r_dc_store, r_owner, r_err;
  logic [ADDR_WIDTH-1:0] r_ic_addr, r_dc_addr;
  logic [LINE_WIDTH-1:0] r_dc_data;
  logic                  w_grant, w_win, w_done, w_stray;
  logic                  w_ic_clr, w_dc_clr, w_ic_cap, w_dc_cap, w_ic_drop, w_dc_drop;
  // r_owner doubles as last_grant: 0 = I$, 1 = D$
  always_comb begin
    w_win   = (r_ic_pend && r_dc_pend) ? ~r_owner : r_dc_pend;
    w_grant = (r_state == S_IDLE) && (r_ic_pend || r_dc_pend);
    w_stray = (r_state == S_IDLE) && bus.mem_rsp_valid;
    w_done  = (r_state == S_WAIT) && bus.mem_rsp_valid;
    w_next  = w_grant ? S_WAIT : (w_done ? S_IDLE : r_state);
  end
  assign w_ic_clr  = w_done && !r_owner;
  assign w_dc_clr  = w_done && r_owner;
  // a slot freed by this cycle's response may be refilled in the same cycle
  assign w_ic_cap  = bus.ic_req_valid && (!r_ic_pend || w_ic_clr);
  assign w_dc_cap  = bus.dc_req_valid && (!r_dc_pend || w_dc_clr);
  assign w_ic_drop = bus.ic_req_valid && !w_ic_cap;
  assign w_dc_drop = bus.dc_req_valid && !w_dc_cap;
  // outputs are forced low while reset is held, even before the first reset edge
  assign bus.mem_req_valid    = i_reset && w_grant;
  assign bus.mem_req_addr     = bus.mem_req_valid ? (w_win ? r_dc_addr : r_ic_addr) : '0;
  assign bus.mem_req_is_store = bus.mem_req_valid && w_win && r_dc_store;
  assign bus.mem_req_data     = bus.mem_req_is_store ? r_dc_data : '0;
  assign bus.ic_rsp_valid     = i_reset && w_ic_clr;
  assign bus.ic_rsp_data      = bus.ic_rsp_valid ? bus.mem_rsp_data : '0;
  assign bus.dc_rsp_valid     = i_reset && w_dc_clr;
  assign bus.dc_rsp_data      = (bus.dc_rsp_valid && !r_dc_store) ? bus.mem_rsp_data : '0;
  assign o_protocol_err       = i_reset && r_err;
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_ic_pend <= 1'b0;
      r_dc_pend <= 1'b0;
      r_owner   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ic_pend <= w_ic_cap || (r_ic_pend && !w_ic_clr);
      r_dc_pend <= w_dc_cap || (r_dc_pend && !w_dc_clr);
      if (w_grant) r_owner <= w_win;
      if (w_stray || w_ic_drop || w_dc_drop) r_err <= 1'b1;
    end
  end
  always_ff @(posedge i_clock) begin
    if (w_ic_cap) r_ic_addr <= bus.ic_req_addr;
    if (w_dc_cap) begin
      r_dc_addr  <= bus.dc_req_addr;
      r_dc_store <= bus.dc_req_is_store;
      r_dc_data  <= bus.dc_req_data;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter.
module tb_mem_arbiter;
  typedef struct packed {
    logic         dc;
    logic [31:0]  addr;
    logic         st;
    logic [127:0] data;
  } req_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;
  int   n_tests = 0;
  int   n_fail = 0;
  req_t exp_q[$];
  req_t cur;
  int   lat;
  mem_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) bus ();
  mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) dut (
    .i_clock(clk), .i_reset(rst_n), .bus(bus), .o_protocol_err(err)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle_inputs();
    bus.ic_req_valid = 0; bus.ic_req_addr = 0;
    bus.dc_req_valid = 0; bus.dc_req_addr = 0; bus.dc_req_is_store = 0; bus.dc_req_data = 0;
    bus.mem_rsp_valid = 0; bus.mem_rsp_data = 0;
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_req"}, bus.mem_req_valid, 0);
    chk({tag, "_ic_rsp"}, bus.ic_rsp_valid, 0);
    chk({tag, "_dc_rsp"}, bus.dc_rsp_valid, 0);
    chk({tag, "_err"}, err, 0);
  endtask
  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    chk_quiet("in_reset");
    cyc();
    cyc();
    rst_n = 1;
    exp_q.delete();
    @(negedge clk);
    chk_quiet("after_reset");
    cyc();
  endtask
  task automatic pulse(input logic ic, input logic [31:0] ia, input logic dc, input logic [31:0] da,
                       input logic st, input logic [127:0] dd);
    bus.ic_req_valid = ic; bus.ic_req_addr = ia;
    bus.dc_req_valid = dc; bus.dc_req_addr = da; bus.dc_req_is_store = st; bus.dc_req_data = dd;
    cyc();
    bus.ic_req_valid = 0;
    bus.dc_req_valid = 0;
  endtask
  task automatic push(input logic dc, input logic [31:0] a, input logic st, input logic [127:0] d);
    req_t r;
    r.dc = dc; r.addr = a; r.st = st; r.data = d;
    exp_q.push_back(r);
  endtask
  // waits for the next memory request and expects it in the very first cycle
  task automatic wait_req(input string tag);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_req_valid) begin
        lat = i;
        if (exp_q.size() == 0) chk({tag, "_unexpected_req"}, 1, 0);
        else begin
          cur = exp_q.pop_front();
          chk({tag, "_addr"}, bus.mem_req_addr, cur.addr);
          chk({tag, "_is_store"}, bus.mem_req_is_store, cur.st);
          if (cur.st) chk({tag, "_wdata"}, bus.mem_req_data, cur.data);
        end
        cyc();
        break;
      end
      cyc();
    end
    chk({tag, "_latency"}, lat, 0);
  endtask
  task automatic respond(input string tag, input int dly, input logic [127:0] d,
                         input logic dcp, input logic [31:0] da);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk({tag, "_no_req_in_wait"}, bus.mem_req_valid, 0);
      cyc();
    end
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = d;
    bus.dc_req_valid = dcp; bus.dc_req_addr = da; bus.dc_req_is_store = 0;
    @(negedge clk);
    chk({tag, "_ic_rsp_valid"}, bus.ic_rsp_valid, !cur.dc);
    chk({tag, "_dc_rsp_valid"}, bus.dc_rsp_valid, cur.dc);
    chk({tag, "_rsp_data"}, cur.dc ? bus.dc_rsp_data : bus.ic_rsp_data, cur.st ? 128'd0 : d);
    chk({tag, "_no_req_at_rsp"}, bus.mem_req_valid, 0);
    cyc();
    bus.mem_rsp_valid = 0; bus.mem_rsp_data = 0; bus.dc_req_valid = 0;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    idle_inputs();
    do_reset();
    // D$ read
    push(1, 32'h100, 0, 0);
    pulse(0, 0, 1, 32'h100, 0, 0);
    wait_req("dc_read");
    respond("dc_read", 10, {16{8'hAA}}, 0, 0);
    // simultaneous pulses after reset: D$ first, then I$
    do_reset();
    push(1, 32'h300, 0, 0);
    push(0, 32'h200, 0, 0);
    pulse(1, 32'h200, 1, 32'h300, 0, 0);
    wait_req("rr1_dc");
    respond("rr1_dc", 3, {4{32'h3333_0001}}, 0, 0);
    wait_req("rr1_ic");
    respond("rr1_ic", 2, {4{32'h2222_0001}}, 0, 0);
    // last grant is I$, so D$ wins again
    push(1, 32'h310, 0, 0);
    push(0, 32'h210, 0, 0);
    pulse(1, 32'h210, 1, 32'h310, 0, 0);
    wait_req("rr2_dc");
    // D$ re-requests in its response cycle; pending I$ (last grant D$) goes next
    push(1, 32'h320, 0, 0);
    respond("rr2_dc", 1, {4{32'h3333_0002}}, 1, 32'h320);
    wait_req("rr3_ic");
    respond("rr3_ic", 1, {4{32'h2222_0002}}, 0, 0);
    wait_req("rr3_dc");
    respond("rr3_dc", 1, {4{32'h3333_0003}}, 0, 0);
    @(negedge clk);
    chk("rr_err_clean", err, 0);
    cyc();
    // D$ evict: ACK returns zero data even though memory drives data
    push(1, 32'h400, 1, {16{8'h5A}});
    pulse(0, 0, 1, 32'h400, 1, {16{8'h5A}});
    wait_req("dc_store");
    respond("dc_store", 4, {16{8'hFF}}, 0, 0);
    // second I$ pulse while pending is dropped and flagged
    do_reset();
    push(0, 32'h500, 0, 0);
    pulse(1, 32'h500, 0, 0, 0, 0);
    wait_req("ic_dup");
    pulse(1, 32'h600, 0, 0, 0, 0);
    @(negedge clk);
    chk("ic_dup_err", err, 1);
    cyc();
    respond("ic_dup", 2, {4{32'h5555_0000}}, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ic_dup_single_req", bus.mem_req_valid, 0);
      cyc();
    end
    // reset abandons an in-flight transaction; the late response is a stray
    do_reset();
    push(1, 32'h800, 0, 0);
    pulse(0, 0, 1, 32'h800, 0, 0);
    wait_req("mid_wait");
    do_reset();
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = {4{32'hDEAD_BEEF}};
    @(negedge clk);
    chk("stray_ic_rsp", bus.ic_rsp_valid, 0);
    chk("stray_dc_rsp", bus.dc_rsp_valid, 0);
    cyc();
    bus.mem_rsp_valid = 0;
    @(negedge clk);
    chk("stray_err", err, 1);
    cyc();
    // D$ pulse in the cycle of its own response is accepted
    do_reset();
    push(1, 32'h700, 0, 0);
    pulse(0, 0, 1, 32'h700, 0, 0);
    wait_req("same_cyc_a");
    push(1, 32'h710, 0, 0);
    respond("same_cyc_a", 2, {4{32'h7777_0000}}, 1, 32'h710);
    wait_req("same_cyc_b");
    respond("same_cyc_b", 2, {4{32'h7777_0001}}, 0, 0);
    @(negedge clk);
    chk("same_cyc_err", err, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
